rf_debug_arbiter: RTL and testbench

- Shares the core's register file between the running core and an external debug/loader requester (UART loader, test harness).
- On a debug request it stalls the core's PC update and drains it to an instruction boundary.
- It then drives the datapath's mem_in_sel / mem_out_sel and register-file write/read interfaces for a burst of debug accesses.
- It releases the core after a programmable idle timeout.
- Sits beside the datapath and control unit in the top level; owns the register-file override muxes.

---
 rtl/rf_debug_arbiter.sv | 101 ++++++++++
 tb/tb_rf_debug_arbiter.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_debug_arbiter.sv
// Register-file arbiter between the core and an external debug/loader requester.
// It halts the core, serves a burst of register reads and writes, then releases the core after an idle timeout.
module rf_debug_arbiter #(
   parameter int IDLE_TIMEOUT = 4,
   parameter int CNT_WIDTH    = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        dbg_req_valid,
   output logic        dbg_req_ready,
   input  logic        dbg_req_we,
   input  logic [4:0]  dbg_req_addr,
   input  logic [31:0] dbg_req_wdata,
   input  logic        dbg_hold,
   output logic        dbg_rsp_valid,
   output logic [31:0] dbg_rsp_rdata,
   output logic        core_stall,
   output logic        core_halted,
   output logic        mem_in_sel,
   output logic        mem_out_sel,
   output logic        rf_wr_en,
   output logic [4:0]  rf_wr_addr,
   output logic [31:0] rf_wr_data,
   output logic [4:0]  rf_rd_addr,
   input  logic [31:0] rf_rd_data
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_HALT,
      ST_ACCESS,
      ST_RELEASE
   } state_e;

   localparam logic [CNT_WIDTH-1:0] LP_CNT_LAST = CNT_WIDTH'(IDLE_TIMEOUT - 1);

   state_e               r_state;
   logic [CNT_WIDTH-1:0] r_idle_cnt;
   logic                 r_rsp_valid;
   logic [31:0]          r_rsp_rdata;

   logic w_access;
   logic w_handshake;

   assign w_access    = (r_state == ST_ACCESS);
   assign w_handshake = w_access & dbg_req_valid;

   // NOTE: every register here uses <= so all updates see the pre-edge values, whatever their order in the block.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_RUN;
         r_idle_cnt  <= '0;
         // NOTE: the response registers sit on the async reset too, so a reset mid-burst drops any in-flight response.
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_handshake;
         r_rsp_rdata <= (w_handshake && !dbg_req_we) ? rf_rd_data : '0;

         case (r_state)
            ST_RUN: begin
               if (dbg_req_valid) r_state <= ST_HALT;
            end
            ST_HALT: begin
               r_state    <= ST_ACCESS;
               r_idle_cnt <= '0;
            end
            ST_ACCESS: begin
               // A handshake in the timeout cycle wins and keeps the burst open.
               if (w_handshake || dbg_hold) begin
                  r_idle_cnt <= '0;
               end else begin
                  if (r_idle_cnt == LP_CNT_LAST) r_state <= ST_RELEASE;
                  if (r_idle_cnt != '1) r_idle_cnt <= r_idle_cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               // Always back to RUN so the core retires at least one instruction between bursts.
               r_state <= ST_RUN;
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign core_stall    = (r_state != ST_RUN);
   assign core_halted   = w_access;
   assign mem_in_sel    = w_access;
   assign mem_out_sel   = w_access;
   assign dbg_req_ready = w_access;

   // x0 is immutable: the write is acknowledged but never reaches the register file.
   assign rf_wr_en   = w_handshake & dbg_req_we & (dbg_req_addr != 5'd0);
   assign rf_wr_addr = w_access ? dbg_req_addr  : '0;
   assign rf_wr_data = w_access ? dbg_req_wdata : '0;
   assign rf_rd_addr = w_access ? dbg_req_addr  : '0;

   assign dbg_rsp_valid = r_rsp_valid;
   assign dbg_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_rf_debug_arbiter.sv
// Bench for rf_debug_arbiter: a cycle table of directed vectors with hand-computed expectations,
// plus a hand-written async-reset-during-burst sequence, run against a small register-file model.
module tb_rf_debug_arbiter;

   typedef enum logic [1:0] {E_RUN, E_HALT, E_ACC, E_REL} st_e;

   typedef struct {
      logic        valid;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic        hold;
      st_e         st;
      logic        wr_en;
      logic        rsp;
      logic [31:0] rdata;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        dbg_req_valid;
   logic        dbg_req_ready;
   logic        dbg_req_we;
   logic [4:0]  dbg_req_addr;
   logic [31:0] dbg_req_wdata;
   logic        dbg_hold;
   logic        dbg_rsp_valid;
   logic [31:0] dbg_rsp_rdata;
   logic        core_stall;
   logic        core_halted;
   logic        mem_in_sel;
   logic        mem_out_sel;
   logic        rf_wr_en;
   logic [4:0]  rf_wr_addr;
   logic [31:0] rf_wr_data;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_data;

   int checks   = 0;
   int failures = 0;

   vec_t tbl[$];

   rf_debug_arbiter #(.IDLE_TIMEOUT(4), .CNT_WIDTH(8)) dut (
      .clk           (clk),
      .reset         (rst_n),
      .dbg_req_valid (dbg_req_valid),
      .dbg_req_ready (dbg_req_ready),
      .dbg_req_we    (dbg_req_we),
      .dbg_req_addr  (dbg_req_addr),
      .dbg_req_wdata (dbg_req_wdata),
      .dbg_hold      (dbg_hold),
      .dbg_rsp_valid (dbg_rsp_valid),
      .dbg_rsp_rdata (dbg_rsp_rdata),
      .core_stall    (core_stall),
      .core_halted   (core_halted),
      .mem_in_sel    (mem_in_sel),
      .mem_out_sel   (mem_out_sel),
      .rf_wr_en      (rf_wr_en),
      .rf_wr_addr    (rf_wr_addr),
      .rf_wr_data    (rf_wr_data),
      .rf_rd_addr    (rf_rd_addr),
      .rf_rd_data    (rf_rd_data)
   );

   // Plain register-file model: writes land whenever rf_wr_en is high, so an x0 write would show on readback.
   logic [31:0] rf_mem [32];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      end else if (rf_wr_en) begin
         rf_mem[rf_wr_addr] <= rf_wr_data;
      end
   end
   assign rf_rd_data = rf_mem[rf_rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic we, input logic [4:0] a, input logic [31:0] d,
                               input logic h, input st_e st, input logic wr, input logic rsp,
                               input logic [31:0] rd);
      vec_t r;
      r.valid = v;  r.we = we;   r.addr = a;   r.wdata = d; r.hold = h;
      r.st    = st; r.wr_en = wr; r.rsp = rsp; r.rdata = rd;
      return r;
   endfunction

   function automatic vec_t idle(input st_e st);
      return mk(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, st, 1'b0, 1'b0, 32'h0);
   endfunction

   // {core_stall, core_halted, dbg_req_ready, mem_in_sel, mem_out_sel} expected for each state
   function automatic logic [4:0] st_bits(input st_e st);
      case (st)
         E_RUN:   return 5'b00000;
         E_HALT:  return 5'b10000;
         E_ACC:   return 5'b11111;
         default: return 5'b10000;
      endcase
   endfunction

   initial begin
      int k;
      logic [38:0] obs;
      logic [38:0] expv;

      dbg_req_valid = 1'b0;
      dbg_req_we    = 1'b0;
      dbg_req_addr  = '0;
      dbg_req_wdata = '0;
      dbg_hold      = 1'b0;
      rst_n         = 1'b1;

      // Reset idle, plus dbg_hold alone in RUN must not halt the core
      for (int i = 0; i < 10; i++) tbl.push_back(idle(E_RUN));
      tbl.push_back(mk(0, 0, 5'd0, 32'h0, 1, E_RUN, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 5'd0, 32'h0, 1, E_RUN, 0, 0, 32'h0));
      tbl.push_back(idle(E_RUN));

      // Single write x5, then release after 4 idle ACCESS cycles
      tbl.push_back(mk(1, 1, 5'd5, 32'hDEADBEEF, 0, E_RUN,  0, 0, 32'h0));
      tbl.push_back(mk(1, 1, 5'd5, 32'hDEADBEEF, 0, E_HALT, 0, 0, 32'h0));
      tbl.push_back(mk(1, 1, 5'd5, 32'hDEADBEEF, 0, E_ACC,  1, 0, 32'h0));
      tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, E_ACC,  0, 1, 32'h0));
      for (int i = 0; i < 3; i++) tbl.push_back(idle(E_ACC));
      tbl.push_back(idle(E_REL));
      tbl.push_back(idle(E_RUN));

      // Back-to-back write/read x7, then a handshake in the timeout cycle keeps the burst open
      tbl.push_back(mk(1, 1, 5'd7, 32'h12345678, 0, E_RUN,  0, 0, 32'h0));
      tbl.push_back(mk(1, 1, 5'd7, 32'h12345678, 0, E_HALT, 0, 0, 32'h0));
      tbl.push_back(mk(1, 1, 5'd7, 32'h12345678, 0, E_ACC,  1, 0, 32'h0));
      tbl.push_back(mk(1, 0, 5'd7, 32'h0,        0, E_ACC,  0, 1, 32'h0));
      tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, E_ACC,  0, 1, 32'h12345678));
      tbl.push_back(idle(E_ACC));
      tbl.push_back(idle(E_ACC));
      tbl.push_back(mk(1, 1, 5'd9, 32'h00000009, 0, E_ACC,  1, 0, 32'h0));
      tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, E_ACC,  0, 1, 32'h0));
      for (int i = 0; i < 3; i++) tbl.push_back(idle(E_ACC));
      tbl.push_back(idle(E_REL));
      tbl.push_back(idle(E_RUN));

      // x0 write is acknowledged but dropped; RELEASE ignores a pending request
      tbl.push_back(mk(1, 1, 5'd0, 32'hFFFFFFFF, 0, E_RUN,  0, 0, 32'h0));
      tbl.push_back(mk(1, 1, 5'd0, 32'hFFFFFFFF, 0, E_HALT, 0, 0, 32'h0));
      tbl.push_back(mk(1, 1, 5'd0, 32'hFFFFFFFF, 0, E_ACC,  0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 5'd0, 32'h0,        0, E_ACC,  0, 1, 32'h0));
      tbl.push_back(mk(0, 0, 5'd0, 32'h0,        0, E_ACC,  0, 1, 32'h0));
      for (int i = 0; i < 3; i++) tbl.push_back(idle(E_ACC));
      tbl.push_back(mk(1, 0, 5'd7, 32'h0, 0, E_REL,  0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 5'd7, 32'h0, 0, E_RUN,  0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 5'd7, 32'h0, 0, E_HALT, 0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 5'd7, 32'h0, 0, E_ACC,  0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 5'd0, 32'h0, 0, E_ACC,  0, 1, 32'h12345678));

      // dbg_hold keeps the core halted; dropping it releases after exactly 4 idle cycles
      for (int i = 0; i < 20; i++) tbl.push_back(mk(0, 0, 5'd0, 32'h0, 1, E_ACC, 0, 0, 32'h0));
      for (int i = 0; i < 4; i++) tbl.push_back(idle(E_ACC));
      tbl.push_back(idle(E_REL));
      tbl.push_back(idle(E_RUN));
      tbl.push_back(idle(E_RUN));

      // Reset values while reset is held
      #3 rst_n = 1'b0;
      #1;
      check("reset_outputs",
            {core_stall, core_halted, dbg_req_ready, mem_in_sel, mem_out_sel, rf_wr_en, dbg_rsp_valid, dbg_rsp_rdata},
            39'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         dbg_req_valid = tbl[i].valid;
         dbg_req_we    = tbl[i].we;
         dbg_req_addr  = tbl[i].addr;
         dbg_req_wdata = tbl[i].wdata;
         dbg_hold      = tbl[i].hold;
         #1;
         obs  = {core_stall, core_halted, dbg_req_ready, mem_in_sel, mem_out_sel, rf_wr_en, dbg_rsp_valid, dbg_rsp_rdata};
         expv = {st_bits(tbl[i].st), tbl[i].wr_en, tbl[i].rsp, tbl[i].rdata};
         check($sformatf("vec%0d", i), {25'h0, obs}, {25'h0, expv});
         if (tbl[i].wr_en)
            check($sformatf("vec%0d_wr_fields", i), {27'h0, rf_wr_addr, rf_wr_data}, {27'h0, tbl[i].addr, tbl[i].wdata});
         if (tbl[i].st == E_ACC)
            check($sformatf("vec%0d_rd_addr", i), {59'h0, rf_rd_addr}, {59'h0, tbl[i].addr});
      end

      // Async reset in the cycle right after a read handshake discards the response
      @(negedge clk);
      dbg_req_valid = 1'b1;
      dbg_req_we    = 1'b0;
      dbg_req_addr  = 5'd5;
      dbg_req_wdata = '0;
      dbg_hold      = 1'b0;
      #1;
      k = 0;
      while (!dbg_req_ready && k < 8) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("mid_reset_reach_access", {63'h0, dbg_req_ready}, 64'h1);
      @(posedge clk);
      #2;
      dbg_req_valid = 1'b0;
      check("mid_reset_rsp_before", {31'h0, dbg_rsp_valid, dbg_rsp_rdata}, {31'h0, 1'b1, 32'hDEADBEEF});
      rst_n = 1'b0;
      #1;
      check("mid_reset_outputs",
            {25'h0, core_stall, core_halted, dbg_req_ready, mem_in_sel, mem_out_sel, rf_wr_en, dbg_rsp_valid, dbg_rsp_rdata},
            64'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         check($sformatf("post_reset%0d", i), {62'h0, core_stall, dbg_rsp_valid}, 64'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
